// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - E-stage multiply/divide request and HI/LO result bundle
interface md_ctrl_if;
   logic [3:0]  md_op_E;
   logic [31:0] A_E;
   logic [31:0] B_E;
   logic        rd_hi_E;
   logic        D_is_md;
   logic        start;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_out;

   modport master (
      output md_op_E, A_E, B_E, rd_hi_E, D_is_md,
      input  start, busy, md_stall, HI, LO, md_out
   );

   modport slave (
      input  md_op_E, A_E, B_E, rd_hi_E, D_is_md,
      output start, busy, md_stall, HI, LO, md_out
   );
endinterface

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - fixed-latency multiply/divide unit owning HI/LO, with stall request
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   md_ctrl_if.slave  md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW    = $clog2(MAX_N + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          busy_q;
   logic          commit_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic [31:0]   hi_tmp;
   logic [31:0]   lo_tmp;

   logic          is_arith;
   logic          is_div;
   logic          start_c;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   b_div_s;
   logic [31:0]   b_div_u;
   logic [31:0]   sq_mag;
   logic [31:0]   sr_mag;
   logic [31:0]   q_s;
   logic [31:0]   r_s;
   logic [31:0]   q_u;
   logic [31:0]   r_u;
   logic [63:0]   res;
   logic          res_ok;

   assign is_arith = (md.md_op_E >= OP_MULT) && (md.md_op_E <= OP_DIVU);
   assign is_div   = (md.md_op_E == OP_DIV) || (md.md_op_E == OP_DIVU);
   assign start_c  = is_arith && (state == IDLE);

   // Signed divide works on magnitudes so MIN/-1 naturally wraps to 0x80000000 with zero remainder.
   always_comb begin
      prod_s  = $signed({{32{md.A_E[31]}}, md.A_E}) * $signed({{32{md.B_E[31]}}, md.B_E});
      prod_u  = {32'd0, md.A_E} * {32'd0, md.B_E};
      a_mag   = md.A_E[31] ? (~md.A_E + 32'd1) : md.A_E;
      b_mag   = md.B_E[31] ? (~md.B_E + 32'd1) : md.B_E;
      b_div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
      b_div_u = (md.B_E == 32'd0) ? 32'd1 : md.B_E;
      sq_mag  = a_mag / b_div_s;
      sr_mag  = a_mag % b_div_s;
      q_s     = (md.A_E[31] ^ md.B_E[31]) ? (~sq_mag + 32'd1) : sq_mag;
      r_s     = md.A_E[31] ? (~sr_mag + 32'd1) : sr_mag;
      q_u     = md.A_E / b_div_u;
      r_u     = md.A_E % b_div_u;
      res     = 64'd0;
      case (md.md_op_E)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = {r_s, q_s};
         OP_DIVU:  res = {r_u, q_u};
         default:  res = 64'd0;
      endcase
      // Divide by zero still occupies the unit but leaves HI/LO untouched.
      res_ok  = !(is_div && (md.B_E == 32'd0));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         commit_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp   <= 32'd0;
         lo_tmp   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start_c) begin
                  hi_tmp   <= res[63:32];
                  lo_tmp   <= res[31:0];
                  commit_q <= res_ok;
                  cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  busy_q   <= 1'b1;
                  state    <= BUSY;
               end else if (md.md_op_E == OP_MTHI) begin
                  hi_q <= md.A_E;
               end else if (md.md_op_E == OP_MTLO) begin
                  lo_q <= md.A_E;
               end
            end
            BUSY: begin
               if (cnt == CW'(1)) begin
                  if (commit_q) begin
                     hi_q <= hi_tmp;
                     lo_q <= lo_tmp;
                  end
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign md.start    = start_c;
   assign md.busy     = busy_q;
   assign md.md_stall = md.D_is_md && (start_c || busy_q);
   assign md.HI       = hi_q;
   assign md.LO       = lo_q;
   assign md.md_out   = md.rd_hi_E ? hi_q : lo_q;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, owns the HI/LO registers and models fixed operation latency.
- Raises a stall request that the hazard unit ORs into its stall term. The stall freezes the PC and D, and bubbles E, whenever a D-stage MD instruction meets a running or starting operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- md_op_E  in  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 treated as NONE.
- A_E  in  32  forwarded rs value (MF_rs_E).
- B_E  in  32  forwarded rt value (MF_rt_E).
- rd_hi_E  in  1  MFHI/MFLO select for md_out: 1 = HI, 0 = LO.
- D_is_md  in  1  D-stage instr is any of MULT..MTLO, MFHI or MFLO.
- start  out  1  combinational; 1 when md_op_E is 1..4 and state is IDLE.
- busy  out  1  registered; 1 while an operation is in flight.
- md_stall  out  1  combinational: D_is_md && (start || busy).
- HI  out  32  HI register.
- LO  out  32  LO register.
- md_out  out  32  combinational: rd_hi_E ? HI : LO.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0, busy=0.
  - HI=LO=0, result latches=0.
  - Reset mid-operation aborts it; the pending result is discarded.
- State IDLE:
  - Trigger: start=1 at edge t.
  - Computes the 64-bit result from A_E/B_E and latches it into hi_tmp/lo_tmp.
  - Loads counter with N (MULT_CYCLES or DIV_CYCLES).
  - Goes to BUSY, with busy=1 from cycle t+1.
- State BUSY:
  - Counter decrements each edge.
  - busy is high for exactly N cycles (t+1..t+N).
  - At the edge ending cycle t+N: HI<=hi_tmp, LO<=lo_tmp, state=IDLE, busy=0.
  - New HI/LO values are first visible in cycle t+N+1.
- Arithmetic:
  - MULT: signed 32x32 -> {HI,LO}. MULTU: unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B_E==0, DIV or DIVU): full N-cycle busy still runs; HI and LO keep their prior values.
- MTHI/MTLO:
  - Apply in IDLE only; write A_E into HI/LO at the edge, zero latency, no busy.
  - Ignored in BUSY; the pipeline guarantees this does not occur via md_stall.
- md_op_E 1..4 arriving while in BUSY is ignored. The hazard unit guarantees it cannot reach E.
- md_stall rules:
  - Asserted in the start cycle as well, so a back-to-back MD instr in D waits.
  - Deasserts in cycle t+N+1, when HI/LO are already updated, so MFHI/MFLO in E reads committed values.
- Bubbles injected by the hazard unit carry md_op_E=0 and have no effect.
- N=1 is supported: busy is high for the single cycle t+1.

Test Plan:
1. Reset low for 2 cycles, then release -> HI=LO=0, busy=0, md_stall=0.
2. MULT A=0xFFFFFFFE, B=3 in cycle 0 -> busy=1 in cycles 1..5, HI=0xFFFFFFFF and LO=0xFFFFFFFA at cycle 6, busy=0.
   - Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU 7/0 -> HI and LO unchanged.
   - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MULT in E with D_is_md=1 held -> md_stall=1 in cycles 0..5 and 0 in cycle 6.
   - Then MFLO in E with rd_hi_E=0 -> md_out=new LO.
5. MTHI A=0x12345678 while IDLE -> HI=0x12345678 the next cycle, busy stays 0.
   - MTLO issued during BUSY -> LO unaffected.
6. Pull reset low at busy cycle 3 of a DIV -> busy=0, HI=LO=0 immediately (asynchronous).
   - No update after release; a new MULT starts normally.
